shift_ser_ctrl: RTL and testbench
=================================

SHIFT_SER_CTRL -- requirements
Module: shift_ser_ctrl

Interface
REQ-001 Parameter: none; width fixed at 8 bits, MSB-first.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_data  input  8  parallel byte to serialize.
REQ-005 i_valid  input  1  i_data valid.
REQ-006 o_ready  output  1  controller can accept a byte.
REQ-007 i_ser_ready  input  1  serial sink accepts the current bit.
REQ-008 o_ser_bit  output  1  current serial bit.
REQ-009 o_ser_valid  output  1  o_ser_bit valid.
REQ-010 o_ser_last  output  1  final bit of the frame.
REQ-011 o_busy  output  1  frame in progress.
REQ-012 o_sr_wr_data  output  8  load value to the 8-bit shift register.
REQ-013 o_sr_wr_data_en  output  1  shift register load enable; when low the register shifts left one bit per clock.
REQ-014 o_sr_wr_bit  output  1  fill bit into the shift register LSB.
REQ-015 i_sr_out  input  1  shift register MSB.
REQ-016 i_sr_whole_reg  input  8  full shift register contents.

Function
REQ-017 States: IDLE, SHIFT, PARITY (PARITY exists only per REQ-030).
REQ-018 IDLE: o_ready=1, o_busy=0, o_ser_valid=0; o_sr_wr_data_en=1, o_sr_wr_data=8'h00 unless accepting.
REQ-019 Accept on i_valid&&o_ready: same cycle o_sr_wr_data=i_data, o_sr_wr_data_en=1; next state SHIFT, bit counter=0, parity register=XOR of i_data.
REQ-020 SHIFT: o_ready=0, o_busy=1, o_ser_valid=1, o_ser_bit=i_sr_out, o_sr_wr_bit=0.
REQ-021 SHIFT, i_ser_ready=1: o_sr_wr_data_en=0 (register shifts), counter increments.
REQ-022 SHIFT, i_ser_ready=0 (stall): o_sr_wr_data_en=1, o_sr_wr_data=i_sr_whole_reg; counter and state hold, o_ser_bit stable.
REQ-023 SHIFT with counter=7 and i_ser_ready=1: counter wraps to 0; next state PARITY if enabled, else IDLE.
REQ-024 o_ser_last=1 in SHIFT at counter=7 when PARITY is disabled; otherwise 0 in SHIFT.
REQ-025 Bit order: i_data[7] first, i_data[0] eighth; first bit visible one cycle after accept.
REQ-026 Frame-to-frame gap: at least one IDLE cycle between frames; o_ready never high while o_busy=1.
REQ-027 All handshake outputs combinational from state, counter, i_ser_ready, i_valid; no combinational path from i_sr_out to o_ready.

Reset
REQ-028 While rst=1 at a rising edge: next state IDLE, counter=0, parity register=0; any in-flight frame is dropped without o_ser_last.
REQ-029 While rst=1: o_ready=0, o_ser_valid=0, o_ser_last=0, o_busy=0, o_ser_bit=0, o_sr_wr_data_en=1, o_sr_wr_data=8'h00, o_sr_wr_bit=0; first accept possible the cycle after rst deasserts.

Configuration
REQ-030 Macro SER_PARITY_EN: defined -> after bit 8 the controller enters PARITY: o_ser_valid=1, o_ser_bit=even-parity bit (XOR of byte), o_ser_last=1, o_sr_wr_data_en=1 with o_sr_wr_data=8'h00; on i_ser_ready=1 -> IDLE, else hold.
REQ-031 SER_PARITY_EN undefined: PARITY state, parity register and its logic absent; frame is exactly 8 bits, last marked on bit 8.

Verification
REQ-032 Reset then i_data=8'hA5, i_valid=1, i_ser_ready=1 -> o_ser_bit 1,0,1,0,0,1,0,1 on 8 consecutive cycles, o_ser_last on 8th (9th = parity 0 if SER_PARITY_EN).
REQ-033 i_data=8'h81 with i_ser_ready=0 for 3 cycles at bit 2 -> o_ser_bit holds 0, o_sr_wr_data=i_sr_whole_reg, stream resumes 0,0,0,0,0,1 afterward.
REQ-034 i_valid held high with 8'hFF then 8'h00 -> second accept exactly one IDLE cycle after the first frame's last beat; o_ready=0 throughout frame.
REQ-035 rst asserted at bit 4 of 8'h3C -> next cycle IDLE, o_busy=0, no o_ser_last; next byte 8'hC3 serializes correctly.
REQ-036 SER_PARITY_EN, i_data=8'h07 -> parity beat o_ser_bit=1 with o_ser_last=1; i_data=8'h03 -> parity 0.

Source files
------------

// File: rtl/shift_ser_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_ser_ctrl
// Description : Controller that serializes one byte at a time, MSB first,
//               through an external 8-bit left-shifting register. It takes a
//               byte with a valid/ready handshake, loads it into the shift
//               register, and presents one bit per beat with a valid/ready
//               handshake on the serial side.
//
//               Optional feature: when the macro SER_PARITY_EN is defined, a
//               ninth beat carrying the even-parity bit (XOR of the byte)
//               follows the data bits. When it is undefined, a frame is
//               exactly eight bits and the parity state and register are not
//               built.
//
// Ports       : clk             - single clock, rising edge
//               rst             - synchronous active-high reset
//               i_data[7:0]     - parallel byte to serialize
//               i_valid         - i_data valid
//               o_ready         - controller can accept a byte
//               i_ser_ready     - serial sink accepts the current bit
//               o_ser_bit       - current serial bit
//               o_ser_valid     - o_ser_bit valid
//               o_ser_last      - final beat of the frame
//               o_busy          - frame in progress
//               o_sr_wr_data    - load value for the shift register
//               o_sr_wr_data_en - load enable; low makes the register shift
//               o_sr_wr_bit     - fill bit shifted into the register LSB
//               i_sr_out        - shift register MSB
//               i_sr_whole_reg  - full shift register contents
//
// Revision    : 1.0 - initial release
// ============================================================================

module shift_ser_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_ser_ready,
  output logic       o_ser_bit,
  output logic       o_ser_valid,
  output logic       o_ser_last,
  output logic       o_busy,
  output logic [7:0] o_sr_wr_data,
  output logic       o_sr_wr_data_en,
  output logic       o_sr_wr_bit,
  input  logic       i_sr_out,
  input  logic [7:0] i_sr_whole_reg
);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
  } state_t;
`endif

  localparam logic [2:0] C_LAST_BIT = 3'd7;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_cnt;
  logic [2:0] w_next_cnt;

`ifdef SER_PARITY_EN
  logic       r_parity;
`endif

  // --------------------------------------------------------------------------
  // State and bit counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

`ifdef SER_PARITY_EN
  // Parity is captured from the byte at accept time, so it does not depend on
  // the shift register contents later in the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if ((r_state == ST_IDLE) && i_valid) begin
      r_parity <= ^i_data;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    // Defaults match the reset/idle-not-accepting view: register held at zero.
    w_next_state    = r_state;
    w_next_cnt      = r_cnt;
    o_ready         = 1'b0;
    o_busy          = 1'b0;
    o_ser_valid     = 1'b0;
    o_ser_bit       = 1'b0;
    o_ser_last      = 1'b0;
    o_sr_wr_data    = 8'h00;
    o_sr_wr_data_en = 1'b1;
    o_sr_wr_bit     = 1'b0;

    // Outputs are forced quiet while reset is applied; the registers are
    // returned to IDLE by the sequential block.
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          o_ready = 1'b1;
          if (i_valid) begin
            o_sr_wr_data = i_data;
            w_next_state = ST_SHIFT;
            w_next_cnt   = 3'd0;
          end
        end

        ST_SHIFT: begin
          o_busy      = 1'b1;
          o_ser_valid = 1'b1;
          o_ser_bit   = i_sr_out;
`ifndef SER_PARITY_EN
          o_ser_last  = (r_cnt == C_LAST_BIT);
`endif
          if (i_ser_ready) begin
            // Let the register shift left so the next bit reaches the MSB.
            o_sr_wr_data_en = 1'b0;
            w_next_cnt      = r_cnt + 3'd1;
            if (r_cnt == C_LAST_BIT) begin
`ifdef SER_PARITY_EN
              w_next_state = ST_PARITY;
`else
              w_next_state = ST_IDLE;
`endif
            end
          end else begin
            // Stall: reload the register with its own value so it holds.
            o_sr_wr_data = i_sr_whole_reg;
          end
        end

`ifdef SER_PARITY_EN
        ST_PARITY: begin
          o_busy      = 1'b1;
          o_ser_valid = 1'b1;
          o_ser_bit   = r_parity;
          o_ser_last  = 1'b1;
          if (i_ser_ready) begin
            w_next_state = ST_IDLE;
          end
        end
`endif

        default: begin
          w_next_state = ST_IDLE;
          w_next_cnt   = 3'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_ser_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_ser_ctrl
// Description : Directed self-checking bench for shift_ser_ctrl. Includes a
//               behavioural model of the external 8-bit shift register.
//               Honours SER_PARITY_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_shift_ser_ctrl;

`ifdef SER_PARITY_EN
  localparam bit C_PAR = 1'b1;
`else
  localparam bit C_PAR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       i_ser_ready;
  logic       o_ser_bit;
  logic       o_ser_valid;
  logic       o_ser_last;
  logic       o_busy;
  logic [7:0] o_sr_wr_data;
  logic       o_sr_wr_data_en;
  logic       o_sr_wr_bit;
  logic [7:0] r_sr;

  int n_checks;
  int n_fail;

  shift_ser_ctrl u_dut (
    .clk             (clk),
    .rst             (rst),
    .i_data          (i_data),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_ser_ready     (i_ser_ready),
    .o_ser_bit       (o_ser_bit),
    .o_ser_valid     (o_ser_valid),
    .o_ser_last      (o_ser_last),
    .o_busy          (o_busy),
    .o_sr_wr_data    (o_sr_wr_data),
    .o_sr_wr_data_en (o_sr_wr_data_en),
    .o_sr_wr_bit     (o_sr_wr_bit),
    .i_sr_out        (r_sr[7]),
    .i_sr_whole_reg  (r_sr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shift register: load when enabled, else shift left with fill.
  always @(posedge clk) begin
    if (o_sr_wr_data_en) r_sr <= o_sr_wr_data;
    else                 r_sr <= {r_sr[6:0], o_sr_wr_bit};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b1; i_data = 8'h5A; i_ser_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if ({o_ready, o_ser_valid, o_ser_last, o_busy, o_ser_bit, o_sr_wr_data_en,
         o_sr_wr_bit, o_sr_wr_data} !== {7'b0000010, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b val=%b last=%b busy=%b bit=%b en=%b wbit=%b data=%h, expected 0 0 0 0 0 1 0 00",
               o_ready, o_ser_valid, o_ser_last, o_busy, o_ser_bit, o_sr_wr_data_en, o_sr_wr_bit, o_sr_wr_data);
    end
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0; #1;
    n_checks++;
    if ({o_ready, o_busy, o_ser_valid, o_sr_wr_data_en, o_sr_wr_data} !== {4'b1001, 8'h00}) begin
      n_fail++;
      $display("FAIL idle_after_reset: got rdy=%b busy=%b val=%b en=%b data=%h, expected 1 0 0 1 00",
               o_ready, o_busy, o_ser_valid, o_sr_wr_data_en, o_sr_wr_data);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_basic_a5();
    logic [7:0] bits;
    bits = 8'b1010_0101;  // expected stream, leftmost first
    @(negedge clk);
    i_valid = 1'b1; i_data = 8'hA5; i_ser_ready = 1'b1; #1;
    n_checks++;
    if ({o_ready, o_sr_wr_data_en, o_sr_wr_data} !== {2'b11, 8'hA5}) begin
      n_fail++;
      $display("FAIL a5_accept: got rdy=%b en=%b data=%h, expected 1 1 a5", o_ready, o_sr_wr_data_en, o_sr_wr_data);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      i_valid = 1'b0; #1;
      n_checks++;
      if ({o_ser_valid, o_ser_bit, o_ser_last, o_ready, o_busy, o_sr_wr_bit, o_sr_wr_data_en} !==
          {1'b1, bits[7-i], (i == 7) && !C_PAR, 4'b0100}) begin
        n_fail++;
        $display("FAIL a5_bit[%0d]: got val=%b bit=%b last=%b rdy=%b busy=%b wbit=%b en=%b, expected 1 %b %b 0 1 0 0",
                 i, o_ser_valid, o_ser_bit, o_ser_last, o_ready, o_busy, o_sr_wr_bit, o_sr_wr_data_en,
                 bits[7-i], (i == 7) && !C_PAR);
      end
    end
`ifdef SER_PARITY_EN
    @(negedge clk); #1;
    n_checks++;
    if ({o_ser_valid, o_ser_bit, o_ser_last, o_ready, o_sr_wr_data_en, o_sr_wr_data} !== {5'b10101, 8'h00}) begin
      n_fail++;
      $display("FAIL a5_parity: got val=%b bit=%b last=%b rdy=%b en=%b data=%h, expected 1 0 1 0 1 00",
               o_ser_valid, o_ser_bit, o_ser_last, o_ready, o_sr_wr_data_en, o_sr_wr_data);
    end
`endif
    @(negedge clk); #1;
    n_checks++;
    if ({o_ready, o_busy, o_ser_valid, o_ser_last} !== 4'b1000) begin
      n_fail++;
      $display("FAIL a5_end_idle: got rdy=%b busy=%b val=%b last=%b, expected 1 0 0 0", o_ready, o_busy, o_ser_valid, o_ser_last);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_stall_81();
    logic [7:0] bits;
    bits = 8'b1000_0001;
    @(negedge clk);
    i_valid = 1'b1; i_data = 8'h81; i_ser_ready = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      i_valid = 1'b0;
      if (i == 2) begin
        i_ser_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          n_checks++;
          // After two shifts of 8'h81 the register holds 8'h04.
          if ({o_ser_valid, o_ser_bit, o_ser_last, o_sr_wr_data_en, o_sr_wr_data} !== {4'b1001, 8'h04}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got val=%b bit=%b last=%b en=%b data=%h, expected 1 0 0 1 04",
                     s, o_ser_valid, o_ser_bit, o_ser_last, o_sr_wr_data_en, o_sr_wr_data);
          end
          @(negedge clk);
        end
        i_ser_ready = 1'b1;
      end
      #1;
      n_checks++;
      if ({o_ser_valid, o_ser_bit, o_ser_last} !== {1'b1, bits[7-i], (i == 7) && !C_PAR}) begin
        n_fail++;
        $display("FAIL stall_bit[%0d]: got val=%b bit=%b last=%b, expected 1 %b %b",
                 i, o_ser_valid, o_ser_bit, o_ser_last, bits[7-i], (i == 7) && !C_PAR);
      end
    end
    if (C_PAR) @(negedge clk);  // parity beat of 8'h81 is 0
    @(negedge clk); #1;
    n_checks++;
    if ({o_ready, o_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL stall_end_idle: got rdy=%b busy=%b, expected 1 0", o_ready, o_busy);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    @(negedge clk);
    i_valid = 1'b1; i_data = 8'hFF; i_ser_ready = 1'b1; #1;
    for (int i = 0; i < 8 + int'(C_PAR); i++) begin
      @(negedge clk);
      i_data = 8'h00; #1;
      n_checks++;
      // Data beats of 8'hFF are all 1; its parity beat is 0.
      if ({o_ready, o_busy, o_ser_valid, o_ser_bit} !== {3'b011, (i < 8)}) begin
        n_fail++;
        $display("FAIL b2b_ff_beat[%0d]: got rdy=%b busy=%b val=%b bit=%b, expected 0 1 1 %b",
                 i, o_ready, o_busy, o_ser_valid, o_ser_bit, (i < 8));
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if ({o_ready, o_busy, o_sr_wr_data_en, o_sr_wr_data} !== {3'b101, 8'h00}) begin
      n_fail++;
      $display("FAIL b2b_gap_accept: got rdy=%b busy=%b en=%b data=%h, expected 1 0 1 00",
               o_ready, o_busy, o_sr_wr_data_en, o_sr_wr_data);
    end
    for (int i = 0; i < 8 + int'(C_PAR); i++) begin
      @(negedge clk);
      i_valid = 1'b0; #1;
      n_checks++;
      if ({o_ready, o_ser_valid, o_ser_bit} !== 3'b010) begin
        n_fail++;
        $display("FAIL b2b_00_beat[%0d]: got rdy=%b val=%b bit=%b, expected 0 1 0", i, o_ready, o_ser_valid, o_ser_bit);
      end
    end
    @(negedge clk); #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_frame();
    logic [7:0] bits;
    @(negedge clk);
    i_valid = 1'b1; i_data = 8'h3C; i_ser_ready = 1'b1; #1;
    bits = 8'b0011_1100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_valid = 1'b0; #1;
      n_checks++;
      if ({o_ser_valid, o_ser_bit} !== {1'b1, bits[7-i]}) begin
        n_fail++;
        $display("FAIL rst3c_bit[%0d]: got val=%b bit=%b, expected 1 %b", i, o_ser_valid, o_ser_bit, bits[7-i]);
      end
    end
    rst = 1'b1; #1;
    n_checks++;
    if ({o_ser_valid, o_ser_last, o_busy, o_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst3c_during: got val=%b last=%b busy=%b rdy=%b, expected 0 0 0 0", o_ser_valid, o_ser_last, o_busy, o_ready);
    end
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b1; i_data = 8'hC3; #1;
    n_checks++;
    if ({o_ready, o_busy, o_ser_valid, o_ser_last, o_sr_wr_data} !== {4'b1000, 8'hC3}) begin
      n_fail++;
      $display("FAIL rst3c_idle: got rdy=%b busy=%b val=%b last=%b data=%h, expected 1 0 0 0 c3",
               o_ready, o_busy, o_ser_valid, o_ser_last, o_sr_wr_data);
    end
    bits = 8'b1100_0011;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      i_valid = 1'b0; #1;
      n_checks++;
      if ({o_ser_valid, o_ser_bit, o_ser_last} !== {1'b1, bits[7-i], (i == 7) && !C_PAR}) begin
        n_fail++;
        $display("FAIL c3_bit[%0d]: got val=%b bit=%b last=%b, expected 1 %b %b",
                 i, o_ser_valid, o_ser_bit, o_ser_last, bits[7-i], (i == 7) && !C_PAR);
      end
    end
    if (C_PAR) @(negedge clk);
    @(negedge clk); #1;
  endtask

`ifdef SER_PARITY_EN
  // --------------------------------------------------------------------------
  task automatic test_parity();
    logic [7:0] bytes [2];
    logic       par   [2];
    bytes[0] = 8'h07; par[0] = 1'b1;
    bytes[1] = 8'h03; par[1] = 1'b0;
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      i_valid = 1'b1; i_data = bytes[f]; i_ser_ready = 1'b1; #1;
      repeat (8) begin
        @(negedge clk);
        i_valid = 1'b0;
      end
      // Parity beat, first stalled for one cycle, then accepted.
      @(negedge clk);
      i_ser_ready = 1'b0;
      for (int s = 0; s < 2; s++) begin
        #1;
        n_checks++;
        if ({o_ser_valid, o_ser_bit, o_ser_last, o_sr_wr_data_en, o_sr_wr_data} !== {1'b1, par[f], 2'b11, 8'h00}) begin
          n_fail++;
          $display("FAIL parity_beat[%0d][%0d]: got val=%b bit=%b last=%b en=%b data=%h, expected 1 %b 1 1 00",
                   f, s, o_ser_valid, o_ser_bit, o_ser_last, o_sr_wr_data_en, o_sr_wr_data, par[f]);
        end
        if (s == 0) @(negedge clk);
        i_ser_ready = 1'b1;
      end
      @(negedge clk); #1;
      n_checks++;
      if ({o_ready, o_busy} !== 2'b10) begin
        n_fail++;
        $display("FAIL parity_end_idle[%0d]: got rdy=%b busy=%b, expected 1 0", f, o_ready, o_busy);
      end
    end
  endtask
`endif

  // --------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_ser_ready = 1'b0;
    test_reset();
    test_basic_a5();
    test_stall_81();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef SER_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
